tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
- Sequencer that executes the CP0 TLB instructions TLBR, TLBWI, TLBWR and TLBP against the 8-entry TLB.
- Sits between the MEM-stage CP0 logic and the TLB module.
  - Latches the CP0 operands.
  - Drives the TLB write, read and search ports.
  - Writes results back to CP0.
  - Owns the Random register.
  - Requests a pipeline refetch after TLB or ASID-affecting updates.

Parameters:
TLB_ENTRIES, 8, number of TLB entries; index width is log2(TLB_ENTRIES)=3.
RD_IDX_W, 5, width of the TLB read-index port.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets)
op_valid  in  1  TLB instruction request
op_ready  out  1  controller can accept a request
op_code  in  2  00=TLBR, 01=TLBWI, 10=TLBWR, 11=TLBP
cp0_index  in  32  CP0 Index
cp0_entryhi  in  32  CP0 EntryHi
cp0_pagemask  in  32  CP0 PageMask
cp0_entrylo0  in  32  CP0 EntryLo0
cp0_entrylo1  in  32  CP0 EntryLo1
cp0_wired  in  32  CP0 Wired; only [2:0] used
wired_wr  in  1  pulse: CP0 Wired is being written this cycle
tlb_we  out  1  TLB write enable
tlb_windex  out  3  TLB write index
tlb_entryhi  out  32  EntryHi to the TLB (write, search, and ASID for translation)
tlb_pagemask  out  32  PageMask to the TLB
tlb_entrylo0  out  32  EntryLo0 to the TLB
tlb_entrylo1  out  32  EntryLo1 to the TLB
tlb_rd_index  out  5  TLB read index
tlb_rd_entryhi  in  32  TLB read data
tlb_rd_pagemask  in  32  TLB read data
tlb_rd_entrylo0  in  32  TLB read data
tlb_rd_entrylo1  in  32  TLB read data
tlb_probe_result  in  32  TLB search result; bit31 = miss
cp0_index_we  out  1  write probe result into CP0 Index
cp0_index_out  out  32  probe result
cp0_tlbr_we  out  1  write TLBR data into CP0
cp0_entryhi_out  out  32  TLBR data to CP0
cp0_pagemask_out  out  32  TLBR data to CP0
cp0_entrylo0_out  out  32  TLBR data to CP0
cp0_entrylo1_out  out  32  TLBR data to CP0
random_out  out  32  CP0 Random value, {29'd0, random}
done  out  1  one-cycle pulse: operation complete
flush_req  out  1  one-cycle pulse, with done: pipeline refetch required

Behaviour:
- States: IDLE, EXEC, WB. op_ready = (state==IDLE).
- Transitions:
  - IDLE -> EXEC on op_valid && op_ready.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
  - op_valid outside IDLE is ignored; no queueing.
- Accept cycle latches: op_code, cp0_index[2:0], cp0_entryhi, cp0_pagemask, cp0_entrylo0/1, and the current random value.
- tlb_entryhi mux: in IDLE it equals live cp0_entryhi, so translation tracks the ASID; in EXEC/WB it equals the latched EntryHi. tlb_pagemask and tlb_entrylo0/1 always drive the latched values.
- EXEC, by op:
  - TLBWI: tlb_we=1 for exactly one cycle, tlb_windex = latched index[2:0].
  - TLBWR: tlb_we=1, tlb_windex = latched random.
  - TLBR: tlb_rd_index = {2'b0, latched index}; TLB read data registered at end of EXEC.
  - TLBP: tlb_probe_result registered at end of EXEC.
- tlb_we is 0 in every other state and op.
- WB, by op:
  - TLBR: cp0_tlbr_we=1; cp0_*_out show the registered read data.
  - TLBP: cp0_index_we=1; cp0_index_out = registered probe result (0x8000_0000 on miss, else {29'd0, idx}).
  - All ops: done=1. flush_req=1 for TLBWI/TLBWR/TLBR, 0 for TLBP.
- Latency: accept at cycle N -> TLB write or read/search at N+1 -> done at N+2. Back-to-back accept is possible at N+3.
- Random register (3 bits):
  - Reset value 7.
  - Decrements every cycle: if random <= wired[2:0], next value is 7; else random-1.
  - Range is therefore [wired, 7].
  - If wired[2:0]==7, random stays 7.
  - wired_wr sets random to 7 next cycle, overriding decrement.
  - TLBWR uses the value latched at accept, unaffected by a same-cycle wired_wr.
- Reset (rst==0 at a clock edge), including mid-operation:
  - state=IDLE, random=7.
  - tlb_we, cp0_index_we, cp0_tlbr_we, done, flush_req = 0.
  - All latched and registered data = 0.
  - Any in-flight operation is dropped with no TLB write and no CP0 write.
- Write enables are exclusive: at most one of tlb_we, cp0_index_we, cp0_tlbr_we is high per cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> op_ready=1, tlb_we=0, done=0, random_out=7, then 6, 5 on following cycles; with wired=2 it sequences 7,6,5,4,3,2,7.
- TLBWI: cp0_index=3, entryhi=0x0040_2005, entrylo0=0x0000_1017, entrylo1=0x0000_1057, accept at N -> tlb_we=1 and windex=3 at N+1 only; done=flush_req=1 at N+2; op_ready=0 at N+1 and N+2.
- TLBWR: wired=4, wired_wr in the same cycle as accept while random=5 -> windex=5 at N+1; random_out=7 at N+1.
- TLBP: bench TLB returns probe 0x0000_0003 -> cp0_index_we=1 with cp0_index_out=3 at N+2 and flush_req=0; repeat with 0x8000_0000 -> cp0_index_out=0x8000_0000.
- TLBR: index=6, TLB returns entryhi=0x1234_A0FF -> tlb_rd_index=6 at N+1; cp0_tlbr_we=1 with cp0_entryhi_out=0x1234_A0FF at N+2; flush_req=1.
- Reset mid-op: TLBWI accepted at N, rst=0 at N+1 edge -> no tlb_we, no done; state is IDLE after reset. Also, op_valid held high continuously is accepted only every 3 cycles.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// Sequencer for the CP0 TLB instructions (TLBR/TLBWI/TLBWR/TLBP) against the TLB.
// Latches CP0 operands, drives TLB ports, writes results back and owns Random.
module tlb_op_ctrl #(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned RD_IDX_W    = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_valid,
  output logic                            op_ready,
  input  logic [1:0]                      op_code,
  input  logic [31:0]                     cp0_index,
  input  logic [31:0]                     cp0_entryhi,
  input  logic [31:0]                     cp0_pagemask,
  input  logic [31:0]                     cp0_entrylo0,
  input  logic [31:0]                     cp0_entrylo1,
  input  logic [31:0]                     cp0_wired,
  input  logic                            wired_wr,
  output logic                            tlb_we,
  output logic [$clog2(TLB_ENTRIES)-1:0]  tlb_windex,
  output logic [31:0]                     tlb_entryhi,
  output logic [31:0]                     tlb_pagemask,
  output logic [31:0]                     tlb_entrylo0,
  output logic [31:0]                     tlb_entrylo1,
  output logic [RD_IDX_W-1:0]             tlb_rd_index,
  input  logic [31:0]                     tlb_rd_entryhi,
  input  logic [31:0]                     tlb_rd_pagemask,
  input  logic [31:0]                     tlb_rd_entrylo0,
  input  logic [31:0]                     tlb_rd_entrylo1,
  input  logic [31:0]                     tlb_probe_result,
  output logic                            cp0_index_we,
  output logic [31:0]                     cp0_index_out,
  output logic                            cp0_tlbr_we,
  output logic [31:0]                     cp0_entryhi_out,
  output logic [31:0]                     cp0_pagemask_out,
  output logic [31:0]                     cp0_entrylo0_out,
  output logic [31:0]                     cp0_entrylo1_out,
  output logic [31:0]                     random_out,
  output logic                            done,
  output logic                            flush_req
);

  localparam int unsigned IdxW = $clog2(TLB_ENTRIES);
  localparam logic [IdxW-1:0] RandMax = IdxW'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;
  typedef enum logic [1:0] {OpTlbr = 2'd0, OpTlbwi = 2'd1, OpTlbwr = 2'd2, OpTlbp = 2'd3} op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] rnd_lat_q, rnd_lat_d;
  logic [IdxW-1:0] random_q, random_d;
  logic [31:0]     ehi_q, ehi_d, pm_q, pm_d, lo0_q, lo0_d, lo1_q, lo1_d;
  logic [31:0]     rd_ehi_q, rd_ehi_d, rd_pm_q, rd_pm_d;
  logic [31:0]     rd_lo0_q, rd_lo0_d, rd_lo1_q, rd_lo1_d;
  logic [31:0]     probe_q, probe_d;
  logic [IdxW-1:0] wired_idx;

  assign wired_idx = cp0_wired[IdxW-1:0];

  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:IdxW], cp0_wired[31:IdxW]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    rnd_lat_d = rnd_lat_q;
    ehi_d     = ehi_q;
    pm_d      = pm_q;
    lo0_d     = lo0_q;
    lo1_d     = lo1_q;
    rd_ehi_d  = rd_ehi_q;
    rd_pm_d   = rd_pm_q;
    rd_lo0_d  = rd_lo0_q;
    rd_lo1_d  = rd_lo1_q;
    probe_d   = probe_q;
    // Random wraps back to the top once it reaches the wired boundary.
    random_d  = (wired_wr || (random_q <= wired_idx)) ? RandMax : random_q - 1'b1;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          state_d   = StExec;
          op_d      = op_e'(op_code);
          idx_d     = cp0_index[IdxW-1:0];
          rnd_lat_d = random_q;
          ehi_d     = cp0_entryhi;
          pm_d      = cp0_pagemask;
          lo0_d     = cp0_entrylo0;
          lo1_d     = cp0_entrylo1;
        end
      end
      StExec: begin
        state_d = StWb;
        if (op_q == OpTlbr) begin
          rd_ehi_d = tlb_rd_entryhi;
          rd_pm_d  = tlb_rd_pagemask;
          rd_lo0_d = tlb_rd_entrylo0;
          rd_lo1_d = tlb_rd_entrylo1;
        end
        if (op_q == OpTlbp) probe_d = tlb_probe_result;
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= OpTlbr;
      idx_q     <= '0;
      rnd_lat_q <= '0;
      random_q  <= RandMax;
      ehi_q     <= '0;
      pm_q      <= '0;
      lo0_q     <= '0;
      lo1_q     <= '0;
      rd_ehi_q  <= '0;
      rd_pm_q   <= '0;
      rd_lo0_q  <= '0;
      rd_lo1_q  <= '0;
      probe_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      rnd_lat_q <= rnd_lat_d;
      random_q  <= random_d;
      ehi_q     <= ehi_d;
      pm_q      <= pm_d;
      lo0_q     <= lo0_d;
      lo1_q     <= lo1_d;
      rd_ehi_q  <= rd_ehi_d;
      rd_pm_q   <= rd_pm_d;
      rd_lo0_q  <= rd_lo0_d;
      rd_lo1_q  <= rd_lo1_d;
      probe_q   <= probe_d;
    end
  end

  // Enables are gated by rst so an in-flight op dropped by reset never commits.
  always_comb begin
    op_ready         = (state_q == StIdle);
    tlb_entryhi      = op_ready ? cp0_entryhi : ehi_q;
    tlb_pagemask     = pm_q;
    tlb_entrylo0     = lo0_q;
    tlb_entrylo1     = lo1_q;
    tlb_windex       = (op_q == OpTlbwr) ? rnd_lat_q : idx_q;
    tlb_rd_index     = {{(RD_IDX_W - IdxW){1'b0}}, idx_q};
    tlb_we           = rst && (state_q == StExec) && ((op_q == OpTlbwi) || (op_q == OpTlbwr));
    done             = rst && (state_q == StWb);
    cp0_tlbr_we      = done && (op_q == OpTlbr);
    cp0_index_we     = done && (op_q == OpTlbp);
    flush_req        = done && (op_q != OpTlbp);
    cp0_index_out    = probe_q;
    cp0_entryhi_out  = rd_ehi_q;
    cp0_pagemask_out = rd_pm_q;
    cp0_entrylo0_out = rd_lo0_q;
    cp0_entrylo1_out = rd_lo1_q;
    random_out       = {{(32 - IdxW){1'b0}}, random_q};
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed plus randomized bench for tlb_op_ctrl; a behavioural model predicts
// the Random sequence and the per-cycle effects of each TLB instruction.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = '0;
  logic [31:0] cp0_index = '0, cp0_entryhi = '0, cp0_pagemask = '0;
  logic [31:0] cp0_entrylo0 = '0, cp0_entrylo1 = '0, cp0_wired = '0;
  logic        wired_wr = 1'b0;
  logic [31:0] tlb_rd_entryhi = '0, tlb_rd_pagemask = '0;
  logic [31:0] tlb_rd_entrylo0 = '0, tlb_rd_entrylo1 = '0, tlb_probe_result = '0;

  logic        op_ready, tlb_we, cp0_index_we, cp0_tlbr_we, done, flush_req;
  logic [2:0]  tlb_windex;
  logic [4:0]  tlb_rd_index;
  logic [31:0] tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1;
  logic [31:0] cp0_index_out, cp0_entryhi_out, cp0_pagemask_out;
  logic [31:0] cp0_entrylo0_out, cp0_entrylo1_out, random_out;

  int errors = 0;
  int checks = 0;
  int unsigned mrand = 7;

  tlb_op_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi), .cp0_pagemask(cp0_pagemask),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_wired(cp0_wired),
    .wired_wr(wired_wr), .tlb_we(tlb_we), .tlb_windex(tlb_windex),
    .tlb_entryhi(tlb_entryhi), .tlb_pagemask(tlb_pagemask), .tlb_entrylo0(tlb_entrylo0),
    .tlb_entrylo1(tlb_entrylo1), .tlb_rd_index(tlb_rd_index),
    .tlb_rd_entryhi(tlb_rd_entryhi), .tlb_rd_pagemask(tlb_rd_pagemask),
    .tlb_rd_entrylo0(tlb_rd_entrylo0), .tlb_rd_entrylo1(tlb_rd_entrylo1),
    .tlb_probe_result(tlb_probe_result), .cp0_index_we(cp0_index_we),
    .cp0_index_out(cp0_index_out), .cp0_tlbr_we(cp0_tlbr_we),
    .cp0_entryhi_out(cp0_entryhi_out), .cp0_pagemask_out(cp0_pagemask_out),
    .cp0_entrylo0_out(cp0_entrylo0_out), .cp0_entrylo1_out(cp0_entrylo1_out),
    .random_out(random_out), .done(done), .flush_req(flush_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; Random follows: reset or wired write -> 7, at/below wired -> 7, else -1.
  task automatic tick();
    if (!rst || wired_wr || mrand <= (cp0_wired & 32'd7)) mrand = 7;
    else mrand = mrand - 1;
    @(posedge clk);
    #1;
    chk("random", random_out, mrand);
  endtask

  task automatic do_op(input logic [1:0] op, input bit wwr, input logic [31:0] idx,
                       input logic [31:0] ehi, input logic [31:0] pm, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [31:0] rhi, input logic [31:0] rpm,
                       input logic [31:0] rlo0, input logic [31:0] rlo1,
                       input logic [31:0] probe);
    logic [31:0] rlat;
    bit          is_wr;
    is_wr = (op == 2'd1) || (op == 2'd2);
    chk("ready_idle", op_ready, 1);
    op_valid = 1; op_code = op; cp0_index = idx; cp0_entryhi = ehi; cp0_pagemask = pm;
    cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; wired_wr = wwr;
    #1;
    chk("ehi_live", tlb_entryhi, ehi);
    rlat = mrand;
    tick();
    // EXEC: scramble CP0 inputs to prove the operands were latched
    op_valid = 0; wired_wr = 0;
    cp0_index = $urandom; cp0_entryhi = $urandom; cp0_pagemask = $urandom;
    cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
    tlb_rd_entryhi = rhi; tlb_rd_pagemask = rpm; tlb_rd_entrylo0 = rlo0;
    tlb_rd_entrylo1 = rlo1; tlb_probe_result = probe;
    #1;
    chk("exec_ready", op_ready, 0);
    chk("exec_we", tlb_we, is_wr);
    if (op == 2'd1) chk("wi_windex", tlb_windex, idx & 32'd7);
    if (op == 2'd2) chk("wr_windex", tlb_windex, rlat);
    if (op == 2'd0) chk("rd_index", tlb_rd_index, idx & 32'd7);
    chk("exec_ehi", tlb_entryhi, ehi);
    chk("exec_pm", tlb_pagemask, pm);
    chk("exec_lo0", tlb_entrylo0, lo0);
    chk("exec_lo1", tlb_entrylo1, lo1);
    chk("exec_done", done, 0);
    chk("exec_cp0we", {cp0_index_we, cp0_tlbr_we}, 0);
    tick();
    // WB: TLB data changes after EXEC and must not leak into CP0 results
    tlb_rd_entryhi = $urandom; tlb_rd_pagemask = $urandom; tlb_rd_entrylo0 = $urandom;
    tlb_rd_entrylo1 = $urandom; tlb_probe_result = $urandom;
    #1;
    chk("wb_ready", op_ready, 0);
    chk("wb_done", done, 1);
    chk("wb_flush", flush_req, op != 2'd3);
    chk("wb_tlb_we", tlb_we, 0);
    chk("wb_tlbr_we", cp0_tlbr_we, op == 2'd0);
    chk("wb_index_we", cp0_index_we, op == 2'd3);
    if (op == 2'd0) begin
      chk("tlbr_ehi", cp0_entryhi_out, rhi);
      chk("tlbr_pm", cp0_pagemask_out, rpm);
      chk("tlbr_lo0", cp0_entrylo0_out, rlo0);
      chk("tlbr_lo1", cp0_entrylo1_out, rlo1);
    end
    if (op == 2'd3) chk("tlbp_index", cp0_index_out, probe);
    tick();
    chk("back_idle", op_ready, 1);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int seq[7];
    int n;
    seq = '{7, 6, 5, 4, 3, 2, 7};

    // Reset and first Random values
    rst = 0; tick(); tick();
    rst = 1; #1;
    chk("rst_ready", op_ready, 1);
    chk("rst_we", tlb_we, 0);
    chk("rst_done", done, 0);
    chk("rst_lo0", tlb_entrylo0, 0);
    chk("rst_random", random_out, 7);
    tick(); chk("rand_6", random_out, 6);
    tick(); chk("rand_5", random_out, 5);

    // Wired = 2 sequence
    cp0_wired = 2; rst = 0; tick(); tick(); rst = 1; #1;
    for (int i = 0; i < 7; i++) begin
      chk("wired2_seq", random_out, seq[i]);
      tick();
    end
    cp0_wired = 0;

    // TLBWI
    do_op(2'd1, 0, 32'd3, 32'h0040_2005, 32'h0, 32'h0000_1017, 32'h0000_1057,
          0, 0, 0, 0, 0);

    // TLBWR with wired write at accept while Random = 5
    cp0_wired = 4;
    n = 0;
    while (mrand != 5 && n < 16) begin tick(); n++; end
    chk("reach_rand5", random_out, 5);
    do_op(2'd2, 1, 32'd0, 32'h0000_0100, 32'h0, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    cp0_wired = 0;

    // TLBP hit and miss
    do_op(2'd3, 0, 32'd0, 32'h0000_3000, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0003);
    do_op(2'd3, 0, 32'd0, 32'h0000_3000, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000);

    // TLBR
    do_op(2'd0, 0, 32'd6, 32'h0, 32'h0, 0, 0, 32'h1234_A0FF, 32'h0000_6000,
          32'h0000_2017, 32'h0000_2057, 0);

    // Reset mid-operation drops the pending TLBWI
    op_valid = 1; op_code = 2'd1; cp0_index = 2; cp0_entryhi = 32'hAAAA_0000;
    tick();
    op_valid = 0; rst = 0; #1;
    chk("midrst_we", tlb_we, 0);
    chk("midrst_done", done, 0);
    tick();
    chk("midrst_ready", op_ready, 1);
    chk("midrst_done2", done, 0);
    rst = 1; cp0_entryhi = 32'h5555_0001; #1;
    chk("midrst_ehi_live", tlb_entryhi, 32'h5555_0001);
    chk("midrst_lo0", tlb_entrylo0, 0);
    tick();
    chk("midrst_we2", tlb_we, 0);
    chk("midrst_done3", done, 0);

    // op_valid held high: accepted only every third cycle
    op_valid = 1; op_code = 2'd3;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      chk("hold_ready", op_ready, (i % 3) == 0);
      chk("hold_done", done, (i % 3) == 2);
      if (done) n++;
      tick();
    end
    op_valid = 0;
    chk("hold_done_count", n, 3);
    tick(); tick();
    chk("hold_idle", op_ready, 1);

    // Randomized operations with random wired, wired writes and idle gaps
    for (int k = 0; k < 40; k++) begin
      int gap;
      cp0_wired = $urandom_range(0, 7);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        wired_wr = ($urandom_range(0, 3) == 0);
        tick();
      end
      wired_wr = 0;
      do_op(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
